// File: rtl/ifm_ctrl_pkg.sv
// Shared types, defaults and helpers for the IFM chunk ping-pong sequencer.
`ifndef WR_DAT_CYC_NUM
`define WR_DAT_CYC_NUM 4
`endif
`ifndef COMPUTE_UNIT_NUM
`define COMPUTE_UNIT_NUM 16
`endif

package ifm_ctrl_pkg;

    localparam int unsigned WR_DAT_CYC_NUM_DFLT   = `WR_DAT_CYC_NUM;
    localparam int unsigned COMPUTE_UNIT_NUM_DFLT = `COMPUTE_UNIT_NUM;
    localparam int unsigned WR_CNT_W_DFLT         = $clog2(WR_DAT_CYC_NUM_DFLT);
    localparam int unsigned CU_MASK_MAX_W         = 64;

    typedef enum logic {
        RD_IDLE,
        RD_RUN
    } rd_state_e;

    // Wide all-ones mask for n units; callers slice to their own width.
    function automatic logic [CU_MASK_MAX_W-1:0] CU_MASK_ALL(input int unsigned n);
        logic [CU_MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < CU_MASK_MAX_W; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ifm_cu_done_tracker.sv
// Collects per-unit done pulses for the chunk being computed and flags completion.
module ifm_cu_done_tracker
    import ifm_ctrl_pkg::*;
#(
    parameter int unsigned COMPUTE_UNIT_NUM = COMPUTE_UNIT_NUM_DFLT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    input  logic [COMPUTE_UNIT_NUM-1:0] cu_done,
    output logic                        all_done,
    output logic [COMPUTE_UNIT_NUM-1:0] cu_active
);

    localparam logic [CU_MASK_MAX_W-1:0]    ALL_WIDE = CU_MASK_ALL(COMPUTE_UNIT_NUM);
    localparam logic [COMPUTE_UNIT_NUM-1:0] ALL      = ALL_WIDE[COMPUTE_UNIT_NUM-1:0];

    logic [COMPUTE_UNIT_NUM-1:0] done_mask;

    // Includes this cycle's pulses so release happens in the cycle of the last done.
    assign all_done  = run && ((done_mask | cu_done) == ALL);
    assign cu_active = run ? ~done_mask : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || all_done) begin
            done_mask <= '0;
        end else if (run) begin
            done_mask <= done_mask | cu_done;
        end
    end

endmodule

// File: rtl/ifm_chunk_pingpong_ctrl.sv
// Two-bank IFM chunk buffer sequencer: loader fills one bank while compute reads the other.
module ifm_chunk_pingpong_ctrl
    import ifm_ctrl_pkg::*;
#(
    parameter int unsigned WR_DAT_CYC_NUM   = WR_DAT_CYC_NUM_DFLT,
    parameter int unsigned COMPUTE_UNIT_NUM = COMPUTE_UNIT_NUM_DFLT,
    localparam int unsigned CNT_W           = $clog2(WR_DAT_CYC_NUM)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        ld_valid_i,
    output logic                        ld_ready_o,
    output logic                        wr_valid_o,
    output logic [CNT_W-1:0]            wr_count_o,
    output logic                        wr_sel_o,
    output logic                        rd_sel_o,
    output logic                        chunk_start_o,
    input  logic [COMPUTE_UNIT_NUM-1:0] cu_done_i,
    output logic [COMPUTE_UNIT_NUM-1:0] cu_active_o,
    output logic [1:0]                  bank_full_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_DAT_CYC_NUM - 1);

    rd_state_e        rd_state, rd_state_nxt;
    logic             wr_sel, wr_sel_nxt;
    logic             rd_sel, rd_sel_nxt;
    logic [CNT_W-1:0] wr_cnt, wr_cnt_nxt;
    logic [1:0]       full, full_nxt;
    logic             chunk_start, chunk_start_nxt;
    logic             all_done;

    assign ld_ready_o    = !full[wr_sel];
    assign wr_valid_o    = ld_valid_i && ld_ready_o;
    assign wr_count_o    = wr_cnt;
    assign wr_sel_o      = wr_sel;
    assign rd_sel_o      = rd_sel;
    assign chunk_start_o = chunk_start;
    assign bank_full_o   = full;

    ifm_cu_done_tracker #(
        .COMPUTE_UNIT_NUM(COMPUTE_UNIT_NUM)
    ) u_tracker (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .run      (rd_state == RD_RUN),
        .cu_done  (cu_done_i),
        .all_done (all_done),
        .cu_active(cu_active_o)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_state    <= RD_IDLE;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_cnt      <= '0;
            full        <= '0;
            chunk_start <= 1'b0;
        end else begin
            rd_state    <= rd_state_nxt;
            wr_sel      <= wr_sel_nxt;
            rd_sel      <= rd_sel_nxt;
            wr_cnt      <= wr_cnt_nxt;
            full        <= full_nxt;
            chunk_start <= chunk_start_nxt;
        end
    end

    always_comb begin
        rd_state_nxt    = rd_state;
        wr_sel_nxt      = wr_sel;
        rd_sel_nxt      = rd_sel;
        wr_cnt_nxt      = wr_cnt;
        full_nxt        = full;
        chunk_start_nxt = 1'b0;

        if (wr_valid_o) begin
            if (wr_cnt == CNT_LAST) begin
                wr_cnt_nxt       = '0;
                full_nxt[wr_sel] = 1'b1;
                wr_sel_nxt       = ~wr_sel;
            end else begin
                wr_cnt_nxt = wr_cnt + CNT_W'(1);
            end
        end

        // Write and read never touch the same full bit in one cycle, so both updates compose.
        case (rd_state)
            RD_IDLE: begin
                if (full[rd_sel]) begin
                    rd_state_nxt    = RD_RUN;
                    chunk_start_nxt = 1'b1;
                end
            end
            RD_RUN: begin
                if (all_done) begin
                    full_nxt[rd_sel] = 1'b0;
                    rd_sel_nxt       = ~rd_sel;
                    if (full[~rd_sel]) begin
                        chunk_start_nxt = 1'b1;
                    end else begin
                        rd_state_nxt = RD_IDLE;
                    end
                end
            end
            default: rd_state_nxt = RD_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ifm_chunk_pingpong_ctrl.sv
// Randomized self-checking bench for ifm_chunk_pingpong_ctrl against a bank-level reference model.
module tb_ifm_chunk_pingpong_ctrl;

    localparam int BEATS = 4;
    localparam int CU    = 16;
    localparam int VW    = 25;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          ld_valid_i = 1'b0;
    logic          ld_ready_o, wr_valid_o, wr_sel_o, rd_sel_o, chunk_start_o;
    logic [1:0]    wr_count_o;
    logic [CU-1:0] cu_done_i = '0;
    logic [CU-1:0] cu_active_o;
    logic [1:0]    bank_full_o;

    int checks = 0;
    int failures = 0;

    // Reference model: banks, a write cursor, and the set of units still owing a done.
    bit            m_full [2];
    bit            m_wbank, m_rbank, m_reading, m_start;
    int            m_beats;
    logic [CU-1:0] m_owed;

    ifm_chunk_pingpong_ctrl #(
        .WR_DAT_CYC_NUM  (BEATS),
        .COMPUTE_UNIT_NUM(CU)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ld_valid_i   (ld_valid_i),
        .ld_ready_o   (ld_ready_o),
        .wr_valid_o   (wr_valid_o),
        .wr_count_o   (wr_count_o),
        .wr_sel_o     (wr_sel_o),
        .rd_sel_o     (rd_sel_o),
        .chunk_start_o(chunk_start_o),
        .cu_done_i    (cu_done_i),
        .cu_active_o  (cu_active_o),
        .bank_full_o  (bank_full_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void model_edge(bit rst_n, bit valid, logic [CU-1:0] done);
        bit            nfull [2];
        bit            nw, nr, nread, nstart;
        int            nbeats;
        logic [CU-1:0] nowed;
        if (!rst_n) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wbank = 0; m_rbank = 0; m_reading = 0; m_start = 0;
            m_beats = 0; m_owed = '0;
            return;
        end
        nfull = m_full; nw = m_wbank; nr = m_rbank; nread = m_reading;
        nbeats = m_beats; nowed = m_owed; nstart = 0;
        if (valid && !m_full[m_wbank]) begin
            nbeats = m_beats + 1;
            if (nbeats == BEATS) begin
                nbeats = 0;
                nfull[m_wbank] = 1;
                nw = !m_wbank;
            end
        end
        if (!m_reading) begin
            if (m_full[m_rbank]) begin
                nread = 1; nstart = 1; nowed = '1;
            end
        end else begin
            nowed = m_owed & ~done;
            if (nowed == '0) begin
                nfull[m_rbank] = 0;
                nr = !m_rbank;
                if (m_full[!m_rbank]) begin
                    nstart = 1; nowed = '1;
                end else begin
                    nread = 0;
                end
            end
        end
        m_full = nfull; m_wbank = nw; m_rbank = nr; m_reading = nread;
        m_beats = nbeats; m_owed = nowed; m_start = nstart;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {ld_ready_o, wr_valid_o, wr_count_o, wr_sel_o, rd_sel_o,
                chunk_start_o, bank_full_o, cu_active_o};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        bit            rdy;
        logic [1:0]    cnt;
        logic [CU-1:0] act;
        rdy = !m_full[m_wbank];
        cnt = 2'(m_beats);
        act = m_reading ? m_owed : '0;
        return {rdy, ld_valid_i & rdy, cnt, m_wbank, m_rbank, m_start,
                m_full[1], m_full[0], act};
    endfunction

    // Drive one cycle of inputs, advance DUT and model across the edge, settle after it.
    task automatic step(input bit rst_n, input bit valid, input logic [CU-1:0] done);
        @(negedge clk_i);
        rst_i = rst_n; ld_valid_i = valid; cu_done_i = done;
        @(posedge clk_i);
        model_edge(rst_n, valid, done);
        #1;
    endtask

    task automatic do_reset();
        step(0, 0, '0);
        step(0, 0, '0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0}) begin
            failures++;
            $display("FAIL reset_values: got %h expected %h", dut_vec(),
                     {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0});
        end
    endtask

    task automatic test_single_chunk();
        for (int k = 0; k < BEATS; k++) begin
            checks++;
            if (wr_count_o !== 2'(k)) begin
                failures++;
                $display("FAIL wr_count_seq[%0d]: got %0d expected %0d", k, wr_count_o, k);
            end
            step(1, 1, '0);
        end
        checks++;
        if ({bank_full_o, wr_sel_o, chunk_start_o} !== {2'b01, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL full_at_T1: got full=%b wsel=%b start=%b expected full=01 wsel=1 start=0",
                     bank_full_o, wr_sel_o, chunk_start_o);
        end
        step(1, 0, '0);
        checks++;
        if ({chunk_start_o, rd_sel_o, cu_active_o} !== {1'b1, 1'b0, 16'hFFFF}) begin
            failures++;
            $display("FAIL start_at_T2: got start=%b rsel=%b act=%h expected 1 0 ffff",
                     chunk_start_o, rd_sel_o, cu_active_o);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < BEATS + 3; k++) begin
            step(1, 1, '0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL backpressure_cyc%0d: got %h expected %h", k, dut_vec(), exp_vec());
            end
        end
        checks++;
        if ({bank_full_o, ld_ready_o, wr_valid_o} !== {2'b11, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL both_full_stall: got full=%b rdy=%b wv=%b expected 11 0 0",
                     bank_full_o, ld_ready_o, wr_valid_o);
        end
    endtask

    task automatic test_staggered_release();
        int            perm [CU];
        logic [CU-1:0] pulse;
        for (int i = 0; i < CU; i++) perm[i] = i;
        for (int i = CU - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(i, 0);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int c = 0; c < 10; c++) begin
            pulse = '0;
            for (int k = 0; k < CU; k++) if (k % 10 == c) pulse[perm[k]] = 1'b1;
            step(1, 1, pulse);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL stagger_cyc%0d: got %h expected %h", c, dut_vec(), exp_vec());
            end
            if (c == 8) begin
                checks++;
                if (bank_full_o !== 2'b11) begin
                    failures++;
                    $display("FAIL early_release: got full=%b expected 11", bank_full_o);
                end
            end
        end
        checks++;
        if ({rd_sel_o, chunk_start_o, ld_ready_o, bank_full_o} !== {1'b1, 1'b1, 1'b1, 2'b10}) begin
            failures++;
            $display("FAIL release: got rsel=%b start=%b rdy=%b full=%b expected 1 1 1 10",
                     rd_sel_o, chunk_start_o, ld_ready_o, bank_full_o);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        for (int k = 0; k < BEATS; k++) step(1, 1, '0);
        step(1, 0, '0);
        for (int k = 0; k < BEATS - 1; k++) step(1, 1, '0);
        step(1, 1, '1);
        checks++;
        if ({bank_full_o, rd_sel_o, chunk_start_o} !== {2'b10, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL same_cycle_swap: got full=%b rsel=%b start=%b expected 10 1 0",
                     bank_full_o, rd_sel_o, chunk_start_o);
        end
        step(1, 0, '0);
        checks++;
        if ({chunk_start_o, rd_sel_o} !== 2'b11) begin
            failures++;
            $display("FAIL same_cycle_start: got start=%b rsel=%b expected 1 1",
                     chunk_start_o, rd_sel_o);
        end
    endtask

    task automatic test_duplicate_done();
        step(1, 0, 16'h0008);
        checks++;
        if (cu_active_o !== 16'hFFF7) begin
            failures++;
            $display("FAIL dup_first: got act=%h expected fff7", cu_active_o);
        end
        step(1, 0, 16'h0008);
        step(1, 0, 16'hFF77);
        step(1, 0, 16'h0008);
        checks++;
        if ({cu_active_o, bank_full_o} !== {16'h0080, 2'b10}) begin
            failures++;
            $display("FAIL missing_unit7: got act=%h full=%b expected 0080 10", cu_active_o, bank_full_o);
        end
        step(1, 0, 16'h0080);
        checks++;
        if ({bank_full_o, rd_sel_o, cu_active_o} !== {2'b00, 1'b0, 16'h0}) begin
            failures++;
            $display("FAIL unit7_release: got full=%b rsel=%b act=%h expected 00 0 0000",
                     bank_full_o, rd_sel_o, cu_active_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < BEATS; k++) step(1, 1, '0);
        step(1, 0, '0);
        step(1, 1, '0);
        step(1, 1, '0);
        checks++;
        if ({wr_count_o, cu_active_o} !== {2'd2, 16'hFFFF}) begin
            failures++;
            $display("FAIL pre_reset_state: got cnt=%0d act=%h expected 2 ffff", wr_count_o, cu_active_o);
        end
        step(0, 0, 16'(($urandom)));
        checks++;
        if (dut_vec() !== {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0}) begin
            failures++;
            $display("FAIL mid_reset: got %h expected %h", dut_vec(),
                     {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 16'h0});
        end
        for (int k = 0; k < BEATS; k++) step(1, 1, '0);
        checks++;
        if ({bank_full_o, wr_sel_o} !== {2'b01, 1'b1}) begin
            failures++;
            $display("FAIL post_reset_fill: got full=%b wsel=%b expected 01 1", bank_full_o, wr_sel_o);
        end
    endtask

    task automatic test_random();
        logic [CU-1:0] d;
        bit            v, r;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(199, 0) != 0);
            v = ($urandom_range(9, 0) < 7);
            d = '0;
            for (int u = 0; u < CU; u++) if ($urandom_range(3, 0) == 0) d[u] = 1'b1;
            step(r, v, d);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cyc%0d: got %h expected %h", c, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_chunk();
        test_backpressure();
        test_staggered_release();
        test_same_cycle();
        test_duplicate_done();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifm_chunk_pingpong_ctrl.md
# ifm_chunk_pingpong_ctrl

Sequencer for the two-bank IFM data-chunk buffer (IFM_Dat_Chunk_Comb_Stacking). It paces the input loader into the fill bank and generates `wr_valid`/`wr_count`/`wr_sel`. It selects the read bank with `rd_sel` and releases that bank only after every compute unit has signalled completion of the current chunk. Write and read sides run concurrently on opposite banks, so chunk N+1 loads while chunk N is computed.

## Interface
- `WR_DAT_CYC_NUM`, default `` `WR_DAT_CYC_NUM `` (4): bus beats per chunk; power of two, ≥2.
- `COMPUTE_UNIT_NUM`, default `` `COMPUTE_UNIT_NUM `` (16): number of consumers.
- `clk_i`, in, 1: single clock, all logic on its rising edge.
- `rst_i`, in, 1: reset, synchronous, active-low.
- `ld_valid_i`, in, 1: loader presents a beat (sparsemap + nonzero data) on the buffer write bus.
- `ld_ready_o`, out, 1: the fill bank can accept a beat.
- `wr_valid_o`, out, 1: write strobe to the buffer, `ld_valid_i & ld_ready_o`.
- `wr_count_o`, out, `$clog2(WR_DAT_CYC_NUM)`: beat index within the chunk.
- `wr_sel_o`, out, 1: bank currently being filled.
- `rd_sel_o`, out, 1: bank currently read by the compute units.
- `chunk_start_o`, out, 1: one-cycle pulse when a new chunk becomes readable on `rd_sel_o`.
- `cu_done_i`, in, `COMPUTE_UNIT_NUM`: per-unit pulse meaning "finished current chunk".
- `cu_active_o`, out, `COMPUTE_UNIT_NUM`: units still owing a done for the current chunk.
- `bank_full_o`, out, 2: per-bank "holds a complete, unreleased chunk".

## Operation
- State: `wr_sel`, `wr_cnt`, `full[1:0]`, `rd_sel`, `done_mask`, and read FSM `rd_state` ∈ {RD_IDLE, RD_RUN}.
- Write side:
  - `ld_ready_o = !full[wr_sel]`; a beat is accepted on `ld_valid_i & ld_ready_o`.
  - Each accepted beat increments `wr_cnt`; the count wraps at `WR_DAT_CYC_NUM-1` to 0.
  - An accepted beat with `wr_cnt == WR_DAT_CYC_NUM-1` sets `full[wr_sel]` and toggles `wr_sel`.
- Read FSM:
  - RD_IDLE: if `full[rd_sel]`, go to RD_RUN and pulse `chunk_start_o` in the first RD_RUN cycle. `cu_done_i` is ignored in RD_IDLE.
  - RD_RUN: `done_mask |= cu_done_i`. When `(done_mask | cu_done_i)` is all ones (completion cycle D):
    - clear `full[rd_sel]`, toggle `rd_sel`, clear `done_mask`;
    - if `full[~rd_sel]` is 1 in cycle D, stay in RD_RUN and pulse `chunk_start_o` at D+1;
    - otherwise go to RD_IDLE.
- `cu_active_o = (rd_state == RD_RUN) ? ~done_mask : '0`.
- `rd_sel_o` is constant throughout a RD_RUN chunk.
- Simultaneous events:
  - The write side setting `full[x]` and the read side clearing `full[y]` in the same cycle is legal; here x ≠ y always, because writes never target a full bank and reads never target a non-full bank.
  - A repeated done from the same unit, or a done for multiple units in one cycle, is idempotent.
- Reset (`rst_i == 0` at a clock edge), including mid-chunk: all state clears and any partial write is discarded. Reset values: `wr_sel_o = 0`, `rd_sel_o = 0`, `wr_count_o = 0`, `bank_full_o = 2'b00`, `chunk_start_o = 0`, `cu_active_o = 0`, `wr_valid_o = 0`, `ld_ready_o = 1` (combinational from cleared state), RD_IDLE.

## Timing
- `wr_valid_o` and `ld_ready_o` are combinational.
- `wr_count_o`, `wr_sel_o`, `rd_sel_o`, `bank_full_o`, and `chunk_start_o` are registered.
- Last beat accepted at T → `bank_full_o[b]` at T+1 → RD_RUN + `chunk_start_o` at T+2 (when RD_IDLE at T+1).
- Completion at D → `rd_sel_o` toggles and `bank_full_o` clears at D+1; back-to-back chunk has `chunk_start_o` at D+1 (zero bubble).
- Full back-pressure: `ld_ready_o` drops the cycle after the second bank fills and rises at D+1 of the next release.
- Sustained throughput: one chunk per max(`WR_DAT_CYC_NUM`, compute time) cycles.

## Structure
- Package `ifm_ctrl_pkg`: `typedef enum logic {RD_IDLE, RD_RUN} rd_state_e`, a `CU_MASK_ALL` helper function, and width localparams derived from the global macros.
- One sub-module, `ifm_cu_done_tracker`: done-mask accumulate/clear, all-done detect, and `cu_active_o`. The remainder stays flat.

## Test plan
- Reset then 4 beats with `ld_valid_i = 1` → `wr_count_o` 0,1,2,3; `bank_full_o = 01` at T+1; `chunk_start_o` at T+2 with `rd_sel_o = 0`; `wr_sel_o = 1`.
- Fill both banks with no done → 8 beats accepted, then `ld_ready_o = 0`, `wr_valid_o = 0` while `ld_valid_i` is held.
- With both banks full, pulse all 16 `cu_done_i` bits staggered over 10 cycles → release at the last pulse, `rd_sel_o = 1`, `chunk_start_o` the next cycle, `ld_ready_o = 1`.
- Same-cycle last write beat into bank 1 and completion of bank 0 → `bank_full_o` goes 01→10, then `chunk_start_o` for bank 1 at the following cycle.
- Duplicate `cu_done_i[3]` pulses plus a missing unit 7 → no release; `cu_active_o = 16'h0080`.
- `rst_i = 0` mid-chunk (`wr_cnt = 2`, RD_RUN) → all outputs at reset values the next cycle; a fresh 4-beat chunk fills bank 0.
